aes_stream_adapter: RTL
=======================

AES_STREAM_ADAPTER -- requirements
Module: aes_stream_adapter

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; ports are listed clock and reset first.
REQ-002 iClk  input  1  rising-edge clock for all state.
REQ-003 iReset  input  1  synchronous active-high reset, sampled on iClk.
REQ-004 iInValid  input  1  upstream word valid.
REQ-005 iInData  input  32  upstream word; four words form one 128-bit block, most significant word first.
REQ-006 iInKey  input  1  block tag; 1 = key block, 0 = plaintext block; sampled only with the first word of a block.
REQ-007 oInReady  output  1  block accepts a word this cycle.
REQ-008 oAesData  output  128  assembled block driven to the AES core in_data.
REQ-009 oLoadKey / oLoadData  output  1 each  single-cycle load pulses to the AES core.
REQ-010 iAesReady  input  1  AES core Ready_new_input.
REQ-011 iCTValid  input  1  AES core ciphertext valid.
REQ-012 iCipherText  input  128  AES core ciphertext.
REQ-013 oOutValid  output  1  downstream word valid.
REQ-014 oOutData  output  32  downstream ciphertext word, most significant word first.
REQ-015 iOutReady  input  1  downstream accepts a word.
REQ-016 oKeyValid  output  1  a key has been loaded since reset.
REQ-017 oDropErr  output  1  single-cycle pulse; a plaintext block was discarded (see REQ-032).

Function
REQ-018 The FSM SHALL have the states FILL, WAIT, ISSUE, RUN and DRAIN.
REQ-019 FILL: oInReady=1; a word SHALL be accepted when iInValid=1; accepted word k (k=0..3) SHALL be written to oAesData[127-32k -: 32].
REQ-020 The 2-bit word counter SHALL wrap from 3 to 0; the fourth accepted word SHALL move the FSM to WAIT on the same clock edge.
REQ-021 iInKey SHALL be latched only when k=0; its value on words 1..3 SHALL be ignored.
REQ-022 In WAIT, ISSUE, RUN and DRAIN, oInReady SHALL be 0 and oAesData SHALL be held stable.
REQ-023 WAIT SHALL move to ISSUE on the first cycle with iAesReady=1 and SHALL wait indefinitely otherwise.
REQ-024 ISSUE SHALL last exactly one cycle and assert oLoadKey (key block) or oLoadData (plaintext block), never both.
REQ-025 After a key ISSUE, the FSM SHALL return to FILL and set oKeyValid=1; after a plaintext ISSUE, it SHALL go to RUN.
REQ-026 RUN: on iCTValid=1, iCipherText SHALL be captured into the result register and the FSM SHALL go to DRAIN with the output index at 0.
REQ-027 iCTValid SHALL be ignored in every state except RUN.
REQ-028 DRAIN: oOutValid=1 and oOutData=result[127-32i -: 32]; the index SHALL advance on iOutReady=1; the fourth transfer SHALL return the FSM to FILL, with oOutValid=0 on the next cycle.
REQ-029 oOutData SHALL remain stable while oOutValid=1 and iOutReady=0.
REQ-030 The input-to-load-pulse latency SHALL be 2 cycles after the fourth word when iAesReady is already 1.

Reset
REQ-031 While iReset=1, on each iClk edge:
- the FSM SHALL go to FILL, both counters to 0, and oAesData and the result register to 0;
- oLoadKey, oLoadData, oOutValid, oKeyValid and oDropErr SHALL go to 0;
- oInReady SHALL be 1 from the first cycle after reset.
A reset in any state SHALL abort the operation in progress with no further pulses.

Configuration
REQ-032 Macro AES_STREAM_KEYCHECK_EN behaviour:
- defined: a plaintext block completed while oKeyValid=0 SHALL skip WAIT/ISSUE, pulse oDropErr for one cycle, and return to FILL without asserting oLoadData;
- undefined: there is no key check, and oDropErr SHALL be tied to 0.

Verification
REQ-033 Key words 00010203,04050607,08090a0b,0c0d0e0f with iInKey=1 and iAesReady=1 -> oAesData=000102030405060708090a0b0c0d0e0f; oLoadKey high for exactly 1 cycle, 2 cycles after the last word; oKeyValid=1.
REQ-034 Plaintext words 00112233..ccddeeff, then iCTValid with iCipherText=69c4e0d86a7b0430d8cdb78070b4c55a -> oLoadData pulses once; output words 69c4e0d8,6a7b0430,d8cdb780,70b4c55a in order.
REQ-035 iAesReady held at 0 for 10 cycles after a full block -> no load pulse and oInReady=0 throughout; pulse occurs 1 cycle after iAesReady rises.
REQ-036 iOutReady toggled 1,0,0,1,1,1 during DRAIN -> exactly 4 transfers, and oOutData is held during stall cycles.
REQ-037 iReset asserted for 1 cycle in RUN, then iCTValid=1 -> oOutValid stays 0, the FSM is in FILL, and oKeyValid=0.
REQ-038 With AES_STREAM_KEYCHECK_EN defined, a plaintext block sent first after reset -> oDropErr pulses once, oLoadData stays 0, and the next block is accepted.

Source files
------------

// File: rtl/aes_stream_adapter_if.sv
// Word-stream / AES-core handshake bundle for aes_stream_adapter.
// The adapter takes the slave view; the upstream/downstream/core side takes master.
interface aes_stream_adapter_if;
  logic         iInValid;
  logic [31:0]  iInData;
  logic         iInKey;
  logic         oInReady;
  logic [127:0] oAesData;
  logic         oLoadKey;
  logic         oLoadData;
  logic         iAesReady;
  logic         iCTValid;
  logic [127:0] iCipherText;
  logic         oOutValid;
  logic [31:0]  oOutData;
  logic         iOutReady;
  logic         oKeyValid;
  logic         oDropErr;

  modport slave (
    input  iInValid, iInData, iInKey, iAesReady, iCTValid, iCipherText, iOutReady,
    output oInReady, oAesData, oLoadKey, oLoadData, oOutValid, oOutData,
           oKeyValid, oDropErr
  );

  modport master (
    output iInValid, iInData, iInKey, iAesReady, iCTValid, iCipherText, iOutReady,
    input  oInReady, oAesData, oLoadKey, oLoadData, oOutValid, oOutData,
           oKeyValid, oDropErr
  );
endinterface

// File: rtl/aes_stream_adapter.sv
// Packs 32-bit words into 128-bit AES blocks, issues key/data loads, and streams ciphertext out.
// Optional AES_STREAM_KEYCHECK_EN: drop plaintext blocks that arrive before any key is loaded.
module aes_stream_adapter (
  input logic                 iClk,
  input logic                 iReset,
  aes_stream_adapter_if.slave bus
);

  typedef enum logic [2:0] {
    FILL,
    WAIT,
    ISSUE,
    RUN,
    DRAIN
  } state_t;

  state_t       state;
  logic [1:0]   word_cnt;
  logic [1:0]   out_idx;
  logic         key_tag;
  logic         key_valid;
  logic         in_ready;
  logic         load_key;
  logic         load_data;
  logic         out_valid;
  logic [31:0]  out_data;
  logic [127:0] aes_data;
  logic [127:0] result;
`ifdef AES_STREAM_KEYCHECK_EN
  logic         drop_err;
`endif

  function automatic logic [31:0] word_of(input logic [127:0] blk, input logic [1:0] idx);
    logic [31:0] w;
    w = '0;
    case (idx)
      2'd0: w = blk[127:96];
      2'd1: w = blk[95:64];
      2'd2: w = blk[63:32];
      2'd3: w = blk[31:0];
      default: w = '0;
    endcase
    return w;
  endfunction

  always_ff @(posedge iClk) begin
    if (iReset) begin
      state     <= FILL;
      word_cnt  <= '0;
      out_idx   <= '0;
      key_tag   <= 1'b0;
      key_valid <= 1'b0;
      in_ready  <= 1'b1;
      load_key  <= 1'b0;
      load_data <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      aes_data  <= '0;
      result    <= '0;
`ifdef AES_STREAM_KEYCHECK_EN
      drop_err  <= 1'b0;
`endif
    end else begin
      load_key  <= 1'b0;
      load_data <= 1'b0;
`ifdef AES_STREAM_KEYCHECK_EN
      drop_err  <= 1'b0;
`endif
      case (state)
        FILL: begin
          if (bus.iInValid) begin
            case (word_cnt)
              2'd0: aes_data[127:96] <= bus.iInData;
              2'd1: aes_data[95:64]  <= bus.iInData;
              2'd2: aes_data[63:32]  <= bus.iInData;
              2'd3: aes_data[31:0]   <= bus.iInData;
              default: ;
            endcase
            if (word_cnt == 2'd0)
              key_tag <= bus.iInKey;
            word_cnt <= word_cnt + 2'd1;
            if (word_cnt == 2'd3) begin
`ifdef AES_STREAM_KEYCHECK_EN
              // key_tag already holds word 0's tag by the time word 3 arrives
              if (!key_tag && !key_valid) begin
                drop_err <= 1'b1;
              end else begin
                state    <= WAIT;
                in_ready <= 1'b0;
              end
`else
              state    <= WAIT;
              in_ready <= 1'b0;
`endif
            end
          end
        end

        WAIT: begin
          if (bus.iAesReady) begin
            state <= ISSUE;
            if (key_tag)
              load_key <= 1'b1;
            else
              load_data <= 1'b1;
          end
        end

        ISSUE: begin
          if (key_tag) begin
            state     <= FILL;
            key_valid <= 1'b1;
            in_ready  <= 1'b1;
          end else begin
            state <= RUN;
          end
        end

        RUN: begin
          if (bus.iCTValid) begin
            result    <= bus.iCipherText;
            out_idx   <= '0;
            out_data  <= bus.iCipherText[127:96];
            out_valid <= 1'b1;
            state     <= DRAIN;
          end
        end

        DRAIN: begin
          if (bus.iOutReady) begin
            if (out_idx == 2'd3) begin
              out_idx   <= '0;
              out_valid <= 1'b0;
              in_ready  <= 1'b1;
              state     <= FILL;
            end else begin
              out_idx  <= out_idx + 2'd1;
              out_data <= word_of(result, out_idx + 2'd1);
            end
          end
        end

        default: state <= FILL;
      endcase
    end
  end

  assign bus.oInReady  = in_ready;
  assign bus.oAesData  = aes_data;
  assign bus.oLoadKey  = load_key;
  assign bus.oLoadData = load_data;
  assign bus.oOutValid = out_valid;
  assign bus.oOutData  = out_data;
  assign bus.oKeyValid = key_valid;
`ifdef AES_STREAM_KEYCHECK_EN
  assign bus.oDropErr  = drop_err;
`else
  assign bus.oDropErr  = 1'b0;
`endif

endmodule
